// File: rtl/rdcntrl_mwin.sv
// rdcntrl_mwin: windowed match/no-match readout controller with descriptor and L1A-number FIFOs
module rdcntrl_mwin #(
    parameter int TMR    = 0,
    parameter int NBLK_W = 4,
    parameter int MAXWIN = 4,
    parameter int FDEPTH = 8,
    parameter int L1AN_W = 6,
    localparam int WS    = $clog2(MAXWIN + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PBEND,
    input  logic [NBLK_W-1:0] BLKIN,
    input  logic              MATCH,
    input  logic              NO_MATCH,
    input  logic              L1A,
    input  logic              GMATCH,
    input  logic [WS-1:0]     WIN_SEL,
    input  logic              RD_ACK,
    output logic              DAV,
    output logic [NBLK_W-1:0] BLKOUT,
    output logic [WS-1:0]     MCNT,
    output logic [L1AN_W-1:0] L1ANUM,
    output logic              NOL1A_MATCH,
    output logic              TEMPTY,
    output logic              FULL,
    output logic              OVF
);
    localparam int HW = (MAXWIN > 1) ? MAXWIN - 1 : 1;
    localparam int AW = $clog2(FDEPTH);
    localparam int CW = AW + 1;
    localparam int DW = NBLK_W + WS;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PRES = 1'b1;

    logic              cur_m, cur_n;
    logic [HW-1:0]     hv, hm, hn;
    logic [NBLK_W-1:0] hb [HW];
    logic [MAXWIN-1:0] sv, sm, sn;
    logic [NBLK_W-1:0] sb [MAXWIN];
    logic [WS-1:0]     w, cnt, e_cnt;
    logic              keep, anyn, selv, e_push, e_nom;
    logic [NBLK_W-1:0] selb, e_blk;
    logic [L1AN_W-1:0] l1a_cnt;

    logic [DW-1:0]     d_mem [FDEPTH];
    logic [AW-1:0]     d_wp, d_rp;
    logic [CW-1:0]     d_n, d_nx;
    logic              d_wr, d_ovf;
    logic [L1AN_W-1:0] l_mem [FDEPTH];
    logic [AW-1:0]     l_wp, l_rp;
    logic [CW-1:0]     l_n, l_nx;
    logic              l_wr, l_ovf, l_empty, l_full;

    logic [0:0]        st, st_a, st_nx;
    logic              pop;

    assign w = (WIN_SEL == '0 || WIN_SEL > WS'(MAXWIN)) ? WS'(MAXWIN) : WIN_SEL;

    // post-shift history view and window evaluation over slots 1..W
    always_comb begin
        sv = '0;
        sm = '0;
        sn = '0;
        sv[0] = 1'b1;
        sb[0] = BLKIN;
        sm[0] = cur_m | MATCH;
        sn[0] = cur_n | NO_MATCH;
        for (int k = 1; k < MAXWIN; k++) begin
            sv[k] = hv[k-1];
            sm[k] = hm[k-1];
            sn[k] = hn[k-1];
            sb[k] = hb[k-1];
        end
        keep = 1'b0;
        anyn = 1'b0;
        cnt  = '0;
        selv = 1'b0;
        selb = '0;
        for (int k = 0; k < MAXWIN; k++) begin
            if (WS'(k + 1) <= w) begin
                keep = keep | sm[k];
                anyn = anyn | sn[k];
                cnt  = cnt + WS'(sm[k]);
            end
            if (WS'(k + 1) == w) begin
                selv = sv[k];
                selb = sb[k];
            end
        end
    end

    // sticky per-block flags and block history shift on PBEND
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cur_m <= 1'b0;
            cur_n <= 1'b0;
            hv    <= '0;
            hm    <= '0;
            hn    <= '0;
            for (int k = 0; k < HW; k++) hb[k] <= '0;
        end else begin
            cur_m <= ~PBEND & (cur_m | MATCH);
            cur_n <= ~PBEND & (cur_n | NO_MATCH);
            if (PBEND) begin
                hv <= sv[HW-1:0];
                hm <= sm[HW-1:0];
                hn <= sn[HW-1:0];
                for (int k = 0; k < HW; k++) hb[k] <= sb[k];
            end
        end
    end

    // registered evaluation result, acted on one cycle later
    always_ff @(posedge CLK) begin
        if (!RST) begin
            e_push      <= 1'b0;
            e_nom       <= 1'b0;
            e_blk       <= '0;
            e_cnt       <= '0;
            NOL1A_MATCH <= 1'b0;
            l1a_cnt     <= '0;
        end else begin
            e_push      <= PBEND & selv & keep;
            e_nom       <= PBEND & selv & ~keep & anyn;
            e_blk       <= selb;
            e_cnt       <= cnt;
            NOL1A_MATCH <= e_nom;
            l1a_cnt     <= l1a_cnt + L1AN_W'(L1A);
        end
    end

    assign d_wr  = e_push & (~FULL | pop);
    assign d_ovf = e_push & FULL & ~pop;
    assign d_nx  = d_n + CW'(d_wr) - CW'(pop);
    assign l_wr  = GMATCH & (~l_full | pop);
    assign l_ovf = GMATCH & l_full & ~pop;
    assign l_nx  = l_n + CW'(l_wr) - CW'(pop);

    // FIFO storage, no reset needed since pointers gate every read
    always_ff @(posedge CLK) begin
        if (d_wr) d_mem[d_wp] <= {e_blk, e_cnt};
        if (l_wr) l_mem[l_wp] <= l1a_cnt;
    end

    // FIFO pointers, occupancy and registered flags
    always_ff @(posedge CLK) begin
        if (!RST) begin
            d_wp    <= '0;
            d_rp    <= '0;
            d_n     <= '0;
            TEMPTY  <= 1'b1;
            FULL    <= 1'b0;
            l_wp    <= '0;
            l_rp    <= '0;
            l_n     <= '0;
            l_empty <= 1'b1;
            l_full  <= 1'b0;
        end else begin
            d_wp    <= d_wp + AW'(d_wr);
            d_rp    <= d_rp + AW'(pop);
            d_n     <= d_nx;
            TEMPTY  <= d_nx == '0;
            FULL    <= d_nx == CW'(FDEPTH);
            l_wp    <= l_wp + AW'(l_wr);
            l_rp    <= l_rp + AW'(pop);
            l_n     <= l_nx;
            l_empty <= l_nx == '0;
            l_full  <= l_nx == CW'(FDEPTH);
        end
    end

    assign pop   = (st == IDLE) & ~TEMPTY & ~l_empty;
    assign st_nx = pop ? PRES : (st == PRES && RD_ACK) ? IDLE : st;
    assign DAV   = st == PRES;

    // readout FSM state register
    always_ff @(posedge CLK) begin
        if (!RST) st_a <= IDLE;
        else      st_a <= st_nx;
    end

    generate
        if (TMR != 0) begin : g_tmr
            logic [0:0] st_b, st_c;
            // redundant copies of the FSM state, majority-voted
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    st_b <= IDLE;
                    st_c <= IDLE;
                end else begin
                    st_b <= st_nx;
                    st_c <= st_nx;
                end
            end
            assign st = (st_a & st_b) | (st_a & st_c) | (st_b & st_c);
        end else begin : g_single
            assign st = st_a;
        end
    endgenerate

    // presented record and sticky overflow
    always_ff @(posedge CLK) begin
        if (!RST) begin
            BLKOUT <= '0;
            MCNT   <= '0;
            L1ANUM <= '0;
            OVF    <= 1'b0;
        end else begin
            if (pop) begin
                {BLKOUT, MCNT} <= d_mem[d_rp];
                L1ANUM         <= l_mem[l_rp];
            end
            OVF <= OVF | d_ovf | l_ovf;
        end
    end
endmodule
